// File: rtl/priority_encoder_83_reg.sv
// Registered 8-to-3 priority encoder with sticky request capture and a valid/ready output.
// Define PRIORITY_ROUND_ROBIN_EN to replace fixed priority (bit 7 highest) with round-robin.
module priority_encoder_83_reg #(
  parameter logic [7:0] RESET_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic       pending_any
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] code_q, code_d;

  logic       handshake;
  logic [7:0] clr;
  logic [7:0] capture;
  logic [7:0] remain;
  logic [2:0] idle_pick;
  logic [2:0] next_pick;

`ifdef PRIORITY_ROUND_ROBIN_EN
  logic [2:0] last_q, last_d;

  // Searches downward from last-1, wrapping 0 -> 7; last itself is considered last.
  function automatic logic [2:0] pick_rr(input logic [7:0] v, input logic [2:0] last);
    logic [2:0] idx;
    pick_rr = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = last - 3'(k);
      if (v[idx]) pick_rr = idx;
    end
  endfunction

  assign idle_pick = pick_rr(pending_q, last_q);
  // The code being accepted becomes the new last grant on the handshake edge.
  assign next_pick = pick_rr(remain, code_q);
  assign last_d    = handshake ? code_q : last_q;
`else
  function automatic logic [2:0] pick_fixed(input logic [7:0] v);
    pick_fixed = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) pick_fixed = 3'(i);
    end
  endfunction

  assign idle_pick = pick_fixed(pending_q);
  assign next_pick = pick_fixed(remain);
`endif

  assign handshake = (state_q == PRESENT) && out_ready;
  assign clr       = handshake ? (8'b1 << code_q) : 8'b0;
  assign capture   = req & mask_q & {8{en}};
  assign remain    = pending_q & ~clr;
  // Set wins over clear so a same-cycle re-request of the accepted bit is not lost.
  assign pending_d = remain | capture;
  assign mask_d    = mask_we ? mask_in : mask_q;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q != 8'b0) begin
          state_d = PRESENT;
          code_d  = idle_pick;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if (remain != 8'b0) begin
            code_d = next_pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'b0;
      mask_q    <= RESET_MASK;
      code_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
    end
  end

`ifdef PRIORITY_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'd7;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign out_valid   = (state_q == PRESENT);
  assign out_code    = code_q;
  assign pending     = pending_q;
  assign pending_any = |pending_q;

`ifndef SYNTHESIS
  a_hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_code)));

  a_presented_is_pending: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> pending[out_code]);
`endif

endmodule

// File: tb/tb_priority_encoder_83_reg.sv
// Directed bench for priority_encoder_83_reg: a behavioural model checked every negedge,
// plus hand-computed literal expectations along the directed sequence.
module tb_priority_encoder_83_reg;

  localparam logic [7:0] RESET_MASK = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [7:0] req = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pending;
  logic       pending_any;

  int n_vec = 0;
  int n_err = 0;

  priority_encoder_83_reg #(.RESET_MASK(RESET_MASK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .pending    (pending),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] m_pend;
  bit [7:0] m_mask;
  bit       m_valid;
  int       m_code;
  int       m_last;

  function automatic int choose(input bit [7:0] v, input int last);
    int p;
`ifdef PRIORITY_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      p = (last - k + 8) % 8;
      if (v[p]) return p;
    end
`else
    for (p = 7; p >= 0; p--) begin
      if (v[p]) return p;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit [7:0] keep;
    if (!rst_n) begin
      m_pend  <= 8'h00;
      m_mask  <= RESET_MASK;
      m_valid <= 1'b0;
      m_code  <= 0;
      m_last  <= 7;
    end else begin
      keep = m_pend;
      if (m_valid && out_ready) keep[m_code] = 1'b0;
      m_pend <= keep | (en ? (req & m_mask) : 8'h00);
      if (mask_we) m_mask <= mask_in;
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_valid <= 1'b1;
          m_code  <= choose(m_pend, m_last);
        end
      end else if (out_ready) begin
        m_last <= m_code;
        if (keep != 0) m_code <= choose(keep, m_code);
        else m_valid <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("pending", 32'(pending), 32'(m_pend));
    check("pending_any", 32'(pending_any), 32'(|m_pend));
    if (m_valid || !rst_n) check("out_code", 32'(out_code), 32'(m_code));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] seq85 [3];

  initial begin
`ifdef PRIORITY_ROUND_ROBIN_EN
    seq85[0] = 3'd2; seq85[1] = 3'd0; seq85[2] = 3'd7;
`else
    seq85[0] = 3'd7; seq85[1] = 3'd2; seq85[2] = 3'd0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pending", 32'(pending), 32'h00);
    check("reset_code", 32'(out_code), 32'd0);
    do_reset();

    // Single pulse on req[4]: 2-cycle latency, then drained.
    out_ready = 1'b1;
    req = 8'h10;
    step();
    check("t1_pending", 32'(pending), 32'h10);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    req = 8'h00;
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_code", 32'(out_code), 32'd4);
    step();
    check("t1_pending_clr", 32'(pending), 32'h00);
    check("t1_idle", 32'(out_valid), 32'd0);

    // Three requests at once, streamed back-to-back.
    do_reset();
    out_ready = 1'b1;
    req = 8'h85;
    step();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_code", 32'(out_code), 32'(seq85[i]));
    end
    step();
    check("t2_idle", 32'(out_valid), 32'd0);

    // Stall holds code 3 while a higher request arrives.
    out_ready = 1'b0;
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    check("t3_code", 32'(out_code), 32'd3);
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 8'h40 : 8'h00;
      step();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_code", 32'(out_code), 32'd3);
    end
    req = 8'h00;
    out_ready = 1'b1;
    step();
    check("t3_next_code", 32'(out_code), 32'd6);
    step(2);

    // Re-request of the bit being accepted keeps it pending.
    req = 8'h20;
    step();
    req = 8'h00;
    step();
    check("t4_code", 32'(out_code), 32'd5);
    req = 8'h20;
    step();
    req = 8'h00;
    check("t4_sticky", 32'(pending), 32'h20);
    step();
    check("t4_again_valid", 32'(out_valid), 32'd1);
    check("t4_again_code", 32'(out_code), 32'd5);
    step(2);

    // Mask blocks upper requests; en=0 blocks everything.
    mask_we = 1'b1;
    mask_in = 8'h0F;
    step();
    mask_we = 1'b0;
    req = 8'hF0;
    step(2);
    check("t5_masked_pending", 32'(pending), 32'h00);
    check("t5_masked_valid", 32'(out_valid), 32'd0);
    req = 8'h00;
    en = 1'b0;
    req = 8'h01;
    step(2);
    check("t5_en_pending", 32'(pending), 32'h00);
    req = 8'h00;

    // Pending drains with en=0 while a code is in flight.
    en = 1'b1;
    out_ready = 1'b0;
    req = 8'h03;
    step();
    req = 8'h00;
    step();
    check("t6_code", 32'(out_code), 32'd1);
    en = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    step();
    check("t6_drain_code", 32'(out_code), 32'd0);
    step();
    check("t6_drained", 32'(pending), 32'h00);
    req = 8'h00;
    en = 1'b1;
    step();

    // Mask left at 0x0F must return to RESET_MASK across a reset.
    do_reset();
    out_ready = 1'b0;
    req = 8'hF0;
    step();
    req = 8'h00;
    check("t7_mask_reset", 32'(pending), 32'hF0);
    do_reset();

    // Asynchronous reset mid-PRESENT with everything pending.
    out_ready = 1'b0;
    req = 8'hFF;
    step();
    req = 8'h00;
    step();
    check("t8_pending_full", 32'(pending), 32'hFF);
    check("t8_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_valid", 32'(out_valid), 32'd0);
    check("t8_async_pending", 32'(pending), 32'h00);
    check("t8_async_any", 32'(pending_any), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("t8_post_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priority_encoder_83_reg.md
Name: priority_encoder_83_reg

Overview:
- Registered 8-to-3 priority encoder with sticky request capture and a valid/ready output handshake.
- It is the inverse of the team's 3-to-8 decoder: up to eight request lines are collapsed into one 3-bit code that a downstream consumer accepts one at a time.
- Sits between event/interrupt sources and a consumer that may stall; no request is lost while the consumer is busy.

Parameters:
- RESET_MASK, 8'hFF, reset value of the internal enable-mask register (bit i = 1 enables capture of req[i]).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global capture enable; 0 blocks new captures only.
- req  input  8  request lines, sampled every clk edge, pulse or level.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  8  new mask value, written when mask_we=1.
- out_ready  input  1  consumer accepts the presented code.
- out_valid  output  1  out_code is valid.
- out_code  output  3  index of the granted request.
- pending  output  8  sticky pending register, for visibility.
- pending_any  output  1  OR-reduction of pending.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, mask=RESET_MASK, out_valid=0, out_code=0, state=IDLE, pending_any=0.
- Capture, each edge: pending_next = (pending & ~clr) | (req & mask & {8{en}}).
  - clr is the one-hot of out_code when out_valid && out_ready, else 0.
  - Set wins over clear: a re-request of the bit being accepted in the same cycle keeps that bit pending.
- Mask:
  - When mask_we=1, mask takes mask_in at the edge.
  - The new mask affects capture from the next cycle.
  - Masking never clears bits that are already pending.
- State machine:
  - IDLE: out_valid=0. If pending≠0 at an edge → PRESENT, with out_code = highest set index of pending (bit 7 highest priority) and out_valid=1.
  - PRESENT: out_code and out_valid are held stable until out_valid && out_ready.
    - On that handshake edge, if (pending & ~clr)≠0, stay in PRESENT and load the next code from pending & ~clr, with no idle bubble.
    - Otherwise go to IDLE.
  - A higher-priority request arriving during PRESENT does not preempt the held code.
- Latency:
  - req[i] high at edge k → pending[i]=1 after edge k.
  - If the block is in IDLE, out_valid=1 with out_code=i after edge k+1. Minimum latency is 2 cycles.
- Throughput: one code per cycle when out_ready is held at 1.
- en=0: no captures; a presented code still completes its handshake, and pending continues to drain.
- out_ready while out_valid=0: ignored.
- pending_any is combinational from pending.
- Reset mid-operation: everything returns to reset values immediately, and the code in flight is dropped.

Optional Feature:
- Macro: PRIORITY_ROUND_ROBIN_EN.
- Defined:
  - A 3-bit last-grant register is added; it resets to 7 and loads out_code at each handshake.
  - The next selection searches downward starting from (last-1) mod 8, wrapping from 0 to 7, so every pending bit is served within 8 grants.
- Undefined:
  - Fixed priority, bit 7 highest; no last-grant register is synthesized.

Test Plan:
- Reset, then 1-cycle pulse req=8'h10 with out_ready=1 → pending=8'h10 after edge 1; out_valid=1, out_code=4 after edge 2; after the handshake, pending=0 and out_valid=0.
- req=8'h85 in one cycle, out_ready=1 → codes 7, 2, 0 on three consecutive cycles, then out_valid=0.
  - With PRIORITY_ROUND_ROBIN_EN, from reset the order is 2, 0, 7.
- Present code 3, hold out_ready=0 for 5 cycles while pulsing req[6] → out_code stays 3 throughout; after out_ready=1, next code is 6.
- Accept code 5 while req[5]=1 in the same cycle → pending[5] stays 1; code 5 is presented again on the next cycle.
- mask_we=1 with mask_in=8'h0F, then req=8'hF0 → no capture, out_valid stays 0; set en=0 and req=8'h01 → no capture.
- Assert rst_n=0 mid-PRESENT with pending=8'hFF → out_valid=0, pending=0, mask=RESET_MASK immediately, before any clock edge.
